// File: rtl/qdma_stm_h2c_pkt_arb.sv
// qdma_stm_h2c_pkt_arb: packet-atomic round-robin arbiter of H2C streams onto one registered AXI-Stream output
module qdma_stm_h2c_pkt_arb #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_DATA_WIDTH = 512,
  parameter int TDEST_BITS = 16,
  parameter int PTR_W = $clog2(NUM_PORTS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS*MAX_DATA_WIDTH-1:0] in_axis_tdata,
  input  logic [NUM_PORTS*TDEST_BITS-1:0]     in_axis_tdest,
  input  logic [NUM_PORTS-1:0]                in_axis_tuser,
  input  logic [NUM_PORTS-1:0]                in_axis_tlast,
  input  logic [NUM_PORTS-1:0]                in_axis_tvalid,
  output logic [NUM_PORTS-1:0]                in_axis_tready,
  output logic [MAX_DATA_WIDTH-1:0]           out_axis_tdata,
  output logic [TDEST_BITS-1:0]               out_axis_tdest,
  output logic                                out_axis_tuser,
  output logic                                out_axis_tlast,
  output logic                                out_axis_tvalid,
  input  logic                                out_axis_tready,
  input  logic [NUM_PORTS-1:0]                port_en,
  output logic [PTR_W-1:0]                    cur_port,
  output logic                                busy,
  output logic [31:0]                         pkt_cnt,
  output logic                                err_hdr_miss
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_nx;
  logic [PTR_W-1:0] last_grant, pick, idx;
  logic [NUM_PORTS-1:0] req;
  logic first_beat, slot_free, hs, hs_last;
  assign req = in_axis_tvalid & port_en;
  assign slot_free = !out_axis_tvalid || out_axis_tready;
  assign hs = busy && in_axis_tvalid[cur_port] && slot_free;
  assign hs_last = hs && in_axis_tlast[cur_port];
  // Descending scan so the nearest requester after last_grant is the one that sticks
  always_comb begin
    pick = last_grant;
    idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = PTR_W'((int'(last_grant) + k) % NUM_PORTS);
      if (req[idx]) pick = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (|req ? XFER : IDLE) : (hs_last ? IDLE : XFER);
  always_comb begin
    busy = (state == XFER);
    in_axis_tready = (busy && slot_free) ? NUM_PORTS'(1) << cur_port : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_port <= '0;
      last_grant <= PTR_W'(NUM_PORTS - 1);
      first_beat <= 1'b0;
      err_hdr_miss <= 1'b0;
      pkt_cnt <= '0;
      out_axis_tvalid <= 1'b0;
      out_axis_tuser <= 1'b0;
      out_axis_tlast <= 1'b0;
      out_axis_tdata <= '0;
      out_axis_tdest <= '0;
    end else begin
      if (state == IDLE && |req) begin
        cur_port <= pick;
        first_beat <= 1'b1;
      end else if (hs) first_beat <= 1'b0;
      if (hs && first_beat && !in_axis_tuser[cur_port]) err_hdr_miss <= 1'b1;
      if (hs_last) last_grant <= cur_port;
      if (hs) begin
        out_axis_tvalid <= 1'b1;
        out_axis_tdata <= in_axis_tdata[cur_port*MAX_DATA_WIDTH +: MAX_DATA_WIDTH];
        out_axis_tdest <= in_axis_tdest[cur_port*TDEST_BITS +: TDEST_BITS];
        out_axis_tuser <= in_axis_tuser[cur_port];
        out_axis_tlast <= in_axis_tlast[cur_port];
      end else if (out_axis_tready) out_axis_tvalid <= 1'b0;
      if (out_axis_tvalid && out_axis_tready && out_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
    end
endmodule
